// File: rtl/cmd_arb_pkg.sv
// Shared types and constants for the cmd_proc port arbiter.
package cmd_arb_pkg;

    // Arbiter FSM states.
    typedef enum logic [1:0] {IDLE, GRANT, EXEC, RESP} state_e;

    // Identity of the requester holding (or last holding) the grant.
    typedef enum logic {HOST, TOUR} owner_e;

    // Host response bytes: command finished while no tour is running / while a tour is busy.
    localparam logic [7:0] RESP_DONE = 8'hA5;
    localparam logic [7:0] RESP_BUSY = 8'h5A;

    // Width of the EXEC watchdog counter.
    localparam int unsigned TMO_W = 26;

endpackage

// File: rtl/cmd_arbiter_wdog.sv
// EXEC-phase watchdog for cmd_arbiter: clears while idle, counts enabled cycles,
// and flags expiry on the cycle the count reaches TMO_CYC-1.
import cmd_arb_pkg::*;

module cmd_wdog #(
    parameter logic [TMO_W-1:0] TMO_CYC = 26'd50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    logic [TMO_W-1:0] cnt_q;
    logic [TMO_W-1:0] cnt_d;

    // Next count: clear has priority, otherwise advance while enabled.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = en && (cnt_q == (TMO_CYC - 1'b1));

endmodule

// File: rtl/cmd_arbiter.sv
// cmd_arbiter: shares the cmd_proc command port between the host (UART_wrapper)
// and the tour move sequencer with round-robin arbitration on ties.
// Optional EXEC watchdog enabled by defining CMD_ARB_TIMEOUT_EN.
import cmd_arb_pkg::*;

module cmd_arbiter #(
    parameter logic [TMO_W-1:0] TMO_CYC = 26'd50_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] host_cmd,
    input  logic        host_cmd_rdy,
    output logic        host_clr,
    input  logic [15:0] tour_cmd,
    input  logic        tour_cmd_rdy,
    output logic        tour_clr,
    input  logic        tour_active,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic        send_resp,
    output logic [7:0]  resp,
    output logic        host_send,
    output logic        tour_done,
    output logic        owner_host,
    output logic        tmo_err
);

    state_e      state_q, state_d;
    owner_e      owner_q, owner_d;
    owner_e      last_owner_q, last_owner_d;
    logic [15:0] cmd_q, cmd_d;
    logic        owner_rdy;
    logic [15:0] owner_cmd;
    logic        wdog_expire;

`ifdef CMD_ARB_TIMEOUT_EN
    cmd_wdog #(
        .TMO_CYC (TMO_CYC)
    ) u_wdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (state_q != EXEC),
        .en     (state_q == EXEC),
        .expire (wdog_expire)
    );
`else
    logic unused_tmo;
    assign unused_tmo  = ^TMO_CYC;
    assign wdog_expire = 1'b0;
`endif

    // Next-state logic and all outputs; the owner's clr passes straight through in GRANT.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        cmd_d        = cmd_q;
        cmd          = cmd_q;
        cmd_rdy      = 1'b0;
        host_clr     = 1'b0;
        tour_clr     = 1'b0;
        host_send    = 1'b0;
        tour_done    = 1'b0;
        tmo_err      = 1'b0;
        resp         = RESP_DONE;
        owner_rdy    = (owner_q == HOST) ? host_cmd_rdy : tour_cmd_rdy;
        owner_cmd    = (owner_q == HOST) ? host_cmd : tour_cmd;

        case (state_q)
            IDLE: begin
                if (host_cmd_rdy || tour_cmd_rdy) begin
                    if (host_cmd_rdy && tour_cmd_rdy) begin
                        owner_d = (last_owner_q == TOUR) ? HOST : TOUR;
                    end else if (host_cmd_rdy) begin
                        owner_d = HOST;
                    end else begin
                        owner_d = TOUR;
                    end
                    last_owner_d = owner_d;
                    state_d      = GRANT;
                end
            end
            GRANT: begin
                cmd   = owner_cmd;
                cmd_d = owner_cmd;
                if (!owner_rdy) begin
                    state_d = IDLE;
                end else begin
                    cmd_rdy = 1'b1;
                    if (clr_cmd_rdy) begin
                        host_clr = (owner_q == HOST);
                        tour_clr = (owner_q == TOUR);
                        state_d  = EXEC;
                    end
                end
            end
            EXEC: begin
                if (send_resp) begin
                    state_d = RESP;
                end else if (wdog_expire) begin
                    tmo_err = 1'b1;
                    state_d = IDLE;
                end
            end
            RESP: begin
                if (owner_q == HOST) begin
                    host_send = 1'b1;
                    resp      = tour_active ? RESP_BUSY : RESP_DONE;
                end else begin
                    tour_done = 1'b1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, ownership and held-command registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            owner_q      <= TOUR;
            last_owner_q <= TOUR;
            cmd_q        <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            cmd_q        <= cmd_d;
        end
    end

    assign owner_host = (state_q != IDLE) && (owner_q == HOST);

endmodule

// File: tb/tb_cmd_arbiter.sv
// Self-checking bench for cmd_arbiter. Completion pulses are scoreboarded:
// tasks push the expected pulse when they drive send_resp, a negedge monitor pops it.
// Timeout scenarios are built in when CMD_ARB_TIMEOUT_EN is defined.
`timescale 1ns/1ps

module tb_cmd_arbiter;

    typedef struct {
        int        kind;   // 0 host_send, 1 tour_done, 2 tmo_err
        logic [7:0] resp;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] host_cmd = '0;
    logic        host_cmd_rdy = 1'b0;
    logic        host_clr;
    logic [15:0] tour_cmd = '0;
    logic        tour_cmd_rdy = 1'b0;
    logic        tour_clr;
    logic        tour_active = 1'b0;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy = 1'b0;
    logic        send_resp = 1'b0;
    logic [7:0]  resp;
    logic        host_send;
    logic        tour_done;
    logic        owner_host;
    logic        tmo_err;

    int   assertions = 0;
    int   failures = 0;
    exp_t exp_q[$];

    cmd_arbiter #(.TMO_CYC(26'd16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .host_cmd     (host_cmd),
        .host_cmd_rdy (host_cmd_rdy),
        .host_clr     (host_clr),
        .tour_cmd     (tour_cmd),
        .tour_cmd_rdy (tour_cmd_rdy),
        .tour_clr     (tour_clr),
        .tour_active  (tour_active),
        .cmd          (cmd),
        .cmd_rdy      (cmd_rdy),
        .clr_cmd_rdy  (clr_cmd_rdy),
        .send_resp    (send_resp),
        .resp         (resp),
        .host_send    (host_send),
        .tour_done    (tour_done),
        .owner_host   (owner_host),
        .tmo_err      (tmo_err)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: every completion/timeout pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && (host_send || tour_done || tmo_err)) begin
            int   kind;
            exp_t e;
            kind = host_send ? 0 : (tour_done ? 1 : 2);
            assertions++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("[TB] FAIL unexpected_pulse: got kind %0d, required no pulse", kind);
            end else begin
                e = exp_q.pop_front();
                if (kind !== e.kind || (kind == 0 && resp !== e.resp)) begin
                    failures++;
                    $display("[TB] FAIL completion: got kind %0d resp %h, required kind %0d resp %h",
                             kind, resp, e.kind, e.resp);
                end
            end
        end
    end

    // Advance to 2 ns after the next rising edge, where inputs are driven.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push_exp(input int kind, input logic [7:0] r);
        exp_t e;
        e.kind = kind;
        e.resp = r;
        exp_q.push_back(e);
    endtask

    task automatic pulse_reset();
        host_cmd_rdy = 1'b0;
        tour_cmd_rdy = 1'b0;
        clr_cmd_rdy  = 1'b0;
        send_resp    = 1'b0;
        tour_active  = 1'b0;
        rst_n        = 1'b0;
        #4;
        rst_n        = 1'b1;
    endtask

    task automatic test_reset();
        #3;
        clr_cmd_rdy = 1'b1;
        send_resp   = 1'b1;
        #1;
        assertions++;
        if ({cmd_rdy, owner_host, host_send, tour_done, tmo_err, host_clr, tour_clr} !== 7'b0) begin
            failures++;
            $display("[TB] FAIL reset_outputs: got %b, required 0000000",
                     {cmd_rdy, owner_host, host_send, tour_done, tmo_err, host_clr, tour_clr});
        end
        assertions++;
        if (resp !== 8'hA5) begin
            failures++;
            $display("[TB] FAIL reset_resp: got %h, required a5", resp);
        end
        clr_cmd_rdy = 1'b0;
        send_resp   = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_host_only();
        step();
        host_cmd = 16'h2002;
        host_cmd_rdy = 1'b1;
        #1;
        assertions++;
        if (cmd_rdy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL host_idle_rdy: got %b, required 0", cmd_rdy);
        end
        step();
        #1;
        assertions++;
        if (cmd_rdy !== 1'b1 || cmd !== 16'h2002 || owner_host !== 1'b1) begin
            failures++;
            $display("[TB] FAIL host_grant: got rdy %b cmd %h own %b, required 1 2002 1", cmd_rdy, cmd, owner_host);
        end
        clr_cmd_rdy = 1'b1;
        #1;
        assertions++;
        if (host_clr !== 1'b1 || tour_clr !== 1'b0) begin
            failures++;
            $display("[TB] FAIL host_clr_route: got host %b tour %b, required 1 0", host_clr, tour_clr);
        end
        step();
        clr_cmd_rdy = 1'b0;
        host_cmd_rdy = 1'b0;
        #1;
        assertions++;
        if (cmd_rdy !== 1'b0 || cmd !== 16'h2002) begin
            failures++;
            $display("[TB] FAIL host_exec: got rdy %b cmd %h, required 0 2002", cmd_rdy, cmd);
        end
        push_exp(0, 8'hA5);
        send_resp = 1'b1;
        step();
        send_resp = 1'b0;
        #1;
        assertions++;
        if (host_send !== 1'b1 || resp !== 8'hA5) begin
            failures++;
            $display("[TB] FAIL host_resp: got send %b resp %h, required 1 a5", host_send, resp);
        end
        step();
        #1;
        assertions++;
        if (owner_host !== 1'b0 || host_send !== 1'b0) begin
            failures++;
            $display("[TB] FAIL host_back_idle: got own %b send %b, required 0 0", owner_host, host_send);
        end
    endtask

    task automatic test_tie();
        step();
        pulse_reset();
        step();
        host_cmd = 16'h3BF1;
        tour_cmd = 16'h2001;
        host_cmd_rdy = 1'b1;
        tour_cmd_rdy = 1'b1;
        step();
        #1;
        assertions++;
        if (owner_host !== 1'b1 || cmd !== 16'h3BF1) begin
            failures++;
            $display("[TB] FAIL tie_first_host: got own %b cmd %h, required 1 3bf1", owner_host, cmd);
        end
        clr_cmd_rdy = 1'b1;
        #1;
        assertions++;
        if (host_clr !== 1'b1 || tour_clr !== 1'b0) begin
            failures++;
            $display("[TB] FAIL tie_clr_route: got host %b tour %b, required 1 0", host_clr, tour_clr);
        end
        step();
        clr_cmd_rdy = 1'b0;
        host_cmd_rdy = 1'b0;
        push_exp(0, 8'hA5);
        send_resp = 1'b1;
        step();
        send_resp = 1'b0;
        step();
        #1;
        assertions++;
        if (cmd_rdy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL tie_idle: got rdy %b, required 0", cmd_rdy);
        end
        step();
        #1;
        assertions++;
        if (owner_host !== 1'b0 || cmd !== 16'h2001 || cmd_rdy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL tie_tour_grant: got own %b cmd %h rdy %b, required 0 2001 1", owner_host, cmd, cmd_rdy);
        end
        clr_cmd_rdy = 1'b1;
        #1;
        assertions++;
        if (tour_clr !== 1'b1 || host_clr !== 1'b0) begin
            failures++;
            $display("[TB] FAIL tie_tour_clr: got tour %b host %b, required 1 0", tour_clr, host_clr);
        end
        step();
        clr_cmd_rdy = 1'b0;
        tour_cmd_rdy = 1'b0;
        push_exp(1, 8'hA5);
        send_resp = 1'b1;
        step();
        send_resp = 1'b0;
        step();
        host_cmd = 16'h1111;
        tour_cmd = 16'h2222;
        host_cmd_rdy = 1'b1;
        tour_cmd_rdy = 1'b1;
        step();
        #1;
        assertions++;
        if (owner_host !== 1'b1 || cmd !== 16'h1111) begin
            failures++;
            $display("[TB] FAIL tie_second_host: got own %b cmd %h, required 1 1111", owner_host, cmd);
        end
        host_cmd_rdy = 1'b0;
        tour_cmd_rdy = 1'b0;
        step();
    endtask

    task automatic test_pending();
        tour_cmd = 16'h2003;
        tour_cmd_rdy = 1'b1;
        step();
        #1;
        assertions++;
        if (owner_host !== 1'b0 || cmd_rdy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL pend_tour_grant: got own %b rdy %b, required 0 1", owner_host, cmd_rdy);
        end
        clr_cmd_rdy = 1'b1;
        step();
        clr_cmd_rdy = 1'b0;
        tour_cmd_rdy = 1'b0;
        host_cmd = 16'h4444;
        host_cmd_rdy = 1'b1;
        for (int c = 0; c < 3; c++) begin
            if (c > 0) step();
            #1;
            assertions++;
            if (cmd !== 16'h2003 || cmd_rdy !== 1'b0 || owner_host !== 1'b0) begin
                failures++;
                $display("[TB] FAIL pend_exec_hold: got cmd %h rdy %b own %b, required 2003 0 0", cmd, cmd_rdy, owner_host);
            end
        end
        push_exp(1, 8'hA5);
        send_resp = 1'b1;
        step();
        send_resp = 1'b0;
        #1;
        assertions++;
        if (cmd !== 16'h2003 || tour_done !== 1'b1) begin
            failures++;
            $display("[TB] FAIL pend_resp: got cmd %h done %b, required 2003 1", cmd, tour_done);
        end
        step();
        #1;
        assertions++;
        if (cmd_rdy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL pend_idle: got rdy %b, required 0", cmd_rdy);
        end
        step();
        #1;
        assertions++;
        if (owner_host !== 1'b1 || cmd !== 16'h4444 || cmd_rdy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL pend_host_grant: got own %b cmd %h rdy %b, required 1 4444 1", owner_host, cmd, cmd_rdy);
        end
        clr_cmd_rdy = 1'b1;
        step();
        clr_cmd_rdy = 1'b0;
        host_cmd_rdy = 1'b0;
        tour_active = 1'b1;
        push_exp(0, 8'h5A);
        send_resp = 1'b1;
        step();
        send_resp = 1'b0;
        #1;
        assertions++;
        if (host_send !== 1'b1 || resp !== 8'h5A) begin
            failures++;
            $display("[TB] FAIL busy_resp: got send %b resp %h, required 1 5a", host_send, resp);
        end
        step();
        tour_active = 1'b0;
    endtask

    task automatic test_withdraw();
        host_cmd = 16'h2004;
        host_cmd_rdy = 1'b1;
        step();
        host_cmd_rdy = 1'b0;
        #1;
        assertions++;
        if (cmd_rdy !== 1'b0 || host_clr !== 1'b0) begin
            failures++;
            $display("[TB] FAIL wd_drop: got rdy %b clr %b, required 0 0", cmd_rdy, host_clr);
        end
        step();
        tour_cmd = 16'h2005;
        tour_cmd_rdy = 1'b1;
        #1;
        assertions++;
        if (owner_host !== 1'b0 || host_send !== 1'b0) begin
            failures++;
            $display("[TB] FAIL wd_idle: got own %b send %b, required 0 0", owner_host, host_send);
        end
        step();
        #1;
        assertions++;
        if (owner_host !== 1'b0 || cmd !== 16'h2005 || cmd_rdy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL wd_tour_grant: got own %b cmd %h rdy %b, required 0 2005 1", owner_host, cmd, cmd_rdy);
        end
        clr_cmd_rdy = 1'b1;
        step();
        clr_cmd_rdy = 1'b0;
        tour_cmd_rdy = 1'b0;
        push_exp(1, 8'hA5);
        send_resp = 1'b1;
        step();
        send_resp = 1'b0;
        step();
    endtask

    task automatic test_wrong_state();
        clr_cmd_rdy = 1'b1;
        send_resp = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            #1;
            assertions++;
            if (host_clr !== 1'b0 || tour_clr !== 1'b0 || cmd_rdy !== 1'b0) begin
                failures++;
                $display("[TB] FAIL stray_ignored: got hclr %b tclr %b rdy %b, required 0 0 0", host_clr, tour_clr, cmd_rdy);
            end
        end
        clr_cmd_rdy = 1'b0;
        send_resp = 1'b0;
        step();
    endtask

    task automatic test_timeout();
        host_cmd = 16'h2006;
        host_cmd_rdy = 1'b1;
        step();
        clr_cmd_rdy = 1'b1;
        step();
        clr_cmd_rdy = 1'b0;
        host_cmd_rdy = 1'b0;
`ifdef CMD_ARB_TIMEOUT_EN
        for (int c = 1; c <= 16; c++) begin
            if (c > 1) step();
            if (c == 16) push_exp(2, 8'hA5);
            #1;
            assertions++;
            if (tmo_err !== (c == 16)) begin
                failures++;
                $display("[TB] FAIL tmo_cycle%0d: got %b, required %b", c, tmo_err, (c == 16));
            end
        end
        step();
        #1;
        assertions++;
        if (owner_host !== 1'b0 || host_send !== 1'b0) begin
            failures++;
            $display("[TB] FAIL tmo_idle: got own %b send %b, required 0 0", owner_host, host_send);
        end
        host_cmd_rdy = 1'b1;
        step();
        clr_cmd_rdy = 1'b1;
        step();
        clr_cmd_rdy = 1'b0;
        host_cmd_rdy = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            if (c > 1) step();
            if (c == 16) begin
                push_exp(0, 8'hA5);
                send_resp = 1'b1;
            end
            #1;
            assertions++;
            if (tmo_err !== 1'b0) begin
                failures++;
                $display("[TB] FAIL tmo_resp_wins%0d: got %b, required 0", c, tmo_err);
            end
        end
        step();
        send_resp = 1'b0;
        #1;
        assertions++;
        if (host_send !== 1'b1) begin
            failures++;
            $display("[TB] FAIL tmo_late_resp: got send %b, required 1", host_send);
        end
        step();
`else
        for (int c = 1; c <= 40; c++) begin
            if (c > 1) step();
            #1;
            assertions++;
            if (tmo_err !== 1'b0 || owner_host !== 1'b1) begin
                failures++;
                $display("[TB] FAIL no_tmo%0d: got tmo %b own %b, required 0 1", c, tmo_err, owner_host);
            end
        end
        push_exp(0, 8'hA5);
        send_resp = 1'b1;
        step();
        send_resp = 1'b0;
        step();
`endif
    endtask

    task automatic test_reset_in_exec();
        host_cmd = 16'h2007;
        host_cmd_rdy = 1'b1;
        step();
        clr_cmd_rdy = 1'b1;
        step();
        host_cmd_rdy = 1'b0;
        rst_n = 1'b0;
        #1;
        assertions++;
        if ({cmd_rdy, owner_host, host_send, tour_done, tmo_err, host_clr, tour_clr} !== 7'b0) begin
            failures++;
            $display("[TB] FAIL reset_exec: got %b, required 0000000",
                     {cmd_rdy, owner_host, host_send, tour_done, tmo_err, host_clr, tour_clr});
        end
        clr_cmd_rdy = 1'b0;
        #2;
        rst_n = 1'b1;
        step();
        step();
        #1;
        assertions++;
        if (owner_host !== 1'b0 || cmd_rdy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_exec_after: got own %b rdy %b, required 0 0", owner_host, cmd_rdy);
        end
    endtask

    // Run every scenario in order, then confirm the scoreboard drained.
    initial begin
        test_reset();
        test_host_only();
        test_tie();
        test_pending();
        test_withdraw();
        test_wrong_state();
        test_timeout();
        test_reset_in_exec();
        step();
        assertions++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule

// File: doc/cmd_arbiter.md
Name: cmd_arbiter

Overview:
- Shares the single cmd_proc command port between two requesters: the host (UART_wrapper) and the tour move sequencer.
- Grants one owner at a time and holds the grant from cmd_rdy through cmd_proc's send_resp.
- Routes clr_cmd_rdy and the completion pulse back to the owner only, and generates the host response byte.
- Sits between UART_wrapper/tour sequencer and cmd_proc; replaces the fixed static mux selection.

Parameters:
- TMO_CYC, 26'd50_000_000, maximum cycles in EXEC waiting for send_resp before the grant is forcibly released (1 s at 50 MHz).

Ports:
- clk  in  1  50 MHz clock
- rst_n  in  1  asynchronous active-low reset
- host_cmd  in  16  command from UART_wrapper
- host_cmd_rdy  in  1  host command valid
- host_clr  out  1  clr_cmd_rdy routed to UART_wrapper
- tour_cmd  in  16  command from tour sequencer
- tour_cmd_rdy  in  1  tour command valid
- tour_clr  out  1  clr_cmd_rdy routed to tour sequencer
- tour_active  in  1  tour in progress (for host response)
- cmd  out  16  command to cmd_proc
- cmd_rdy  out  1  command valid to cmd_proc
- clr_cmd_rdy  in  1  accept pulse from cmd_proc
- send_resp  in  1  completion pulse from cmd_proc
- resp  out  8  host response byte
- host_send  out  1  1-cycle pulse: transmit resp to host
- tour_done  out  1  1-cycle pulse: tour command completed
- owner_host  out  1  high while host holds the grant
- tmo_err  out  1  1-cycle pulse on watchdog expiry

Behaviour:
- Reset values: state IDLE; last_owner = TOUR (so host wins the first tie); all pulses 0; cmd_rdy 0; owner_host 0.
- Reset mid-operation aborts the grant; no clr or done pulse is emitted.

States:
- IDLE
  - Single requester → grant it.
  - Both requesting → grant the one that is not last_owner (round-robin); record the winner as last_owner.
  - Next state GRANT. Grant decision takes 1 cycle, so cmd_rdy rises the cycle after the request is seen.
- GRANT
  - cmd = owner's cmd; cmd_rdy = owner's rdy.
  - clr_cmd_rdy passes combinationally, same cycle, to the owner's clr only; next state EXEC.
  - If the owner drops rdy before clr_cmd_rdy (withdrawal) → IDLE with no pulses; last_owner is kept.
- EXEC
  - cmd holds the owner's cmd; cmd_rdy = 0.
  - On send_resp → RESP.
  - Requests from the other requester are held pending and not lost: they are level rdy signals.
- RESP (1 cycle)
  - Host owner: host_send = 1; resp = 8'hA5 if !tour_active, else 8'h5A.
  - Tour owner: tour_done = 1.
  - Then → IDLE.
- Outside RESP, resp = 8'hA5.
- Non-owner clr outputs are always 0. A clr_cmd_rdy or send_resp received in the wrong state is ignored.
- owner_host = 1 in GRANT/EXEC/RESP when the host owns the grant.
- Minimum turnaround per command is 4 cycles (IDLE→GRANT→EXEC→RESP).

Optional Feature:
- Macro CMD_ARB_TIMEOUT_EN.
- Defined:
  - 26-bit watchdog clears on entry to EXEC and counts each EXEC cycle.
  - Reaching TMO_CYC-1 without send_resp → tmo_err pulse → IDLE.
  - No host_send or tour_done pulse; last_owner is kept.
  - send_resp in the same cycle as expiry wins (normal RESP, no tmo_err).
- Undefined: no counter; EXEC waits indefinitely; tmo_err tied 0.

Decomposition:
- Package cmd_arb_pkg:
  - state enum {IDLE, GRANT, EXEC, RESP}
  - owner enum {HOST, TOUR}
  - localparams RESP_DONE = 8'hA5, RESP_BUSY = 8'h5A
- Sub-module cmd_wdog: counter with clr, en and expire output, instantiated only under CMD_ARB_TIMEOUT_EN.

Test Plan:
- Host only: host_cmd = 16'h2002, rdy → cmd = 16'h2002, cmd_rdy the next cycle; clr_cmd_rdy → host_clr the same cycle, tour_clr 0; send_resp with tour_active = 0 → host_send pulse, resp = 8'hA5.
- Simultaneous requests after reset: host 16'h3BF1, tour 16'h2001 → host granted first; after its send_resp, tour granted; tour_done pulse; next tie goes to host.
- Tour owner in EXEC while host asserts rdy → host waits; cmd stays at the tour cmd until RESP; host granted the cycle after IDLE.
- Host rdy dropped in GRANT before clr → IDLE, no host_clr or host_send; a following tour request is granted.
- Host command with tour_active = 1 → resp = 8'h5A on host_send.
- CMD_ARB_TIMEOUT_EN with TMO_CYC = 16: no send_resp → tmo_err after 16 EXEC cycles, IDLE; repeat with send_resp on cycle 16 → RESP, no tmo_err; assert rst_n low in EXEC → IDLE, all outputs 0.
